// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder
// Scans a ROWS x COLS key matrix one row at a time and corrects the polarity of
// each key individually. It debounces whole frames, publishes the debounced
// level vector, and queues one press event per newly pressed key. The events
// leave over a valid/ready handshake.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   row_n      out  [ROWS-1:0] row drive, active low, one row low at a time
//   col_n      in   [COLS-1:0] column sense, active low, already synchronised
//   key_state  out  [ROWS*COLS-1:0] debounced pressed level, bit i = key i
//   key_valid  out  press event available on key_code
//   key_code   out  [CW-1:0] index (r*COLS + c) of the pressed key
//   key_ready  in   consumer accepts the event when key_valid & key_ready
//   key_drop   out  one-cycle pulse: a new press hit a key already pending
module keypad_scan_decoder #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter logic [ROWS*COLS-1:0] INVERT_MASK = '0,
  localparam int KEYS = ROWS * COLS,
  localparam int CW   = (KEYS > 1) ? $clog2(KEYS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] row_n,
  input  logic [COLS-1:0] col_n,
  output logic [KEYS-1:0] key_state,
  output logic            key_valid,
  output logic [CW-1:0]   key_code,
  input  logic            key_ready,
  output logic            key_drop
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0]   DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [SW-1:0]   STABLE_MAX = SW'(DEBOUNCE_FRAMES);
  localparam logic [ROWS-1:0] ROW_ONE    = ROWS'(1'b1);
  localparam logic [KEYS-1:0] KEY_ONE    = KEYS'(1'b1);

  // Lowest set bit of a key vector; returns 0 when the vector is empty.
  function automatic logic [CW-1:0] lowest_idx(input logic [KEYS-1:0] vec);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      idx = vec[i] ? CW'(i) : idx;
    end
    return idx;
  endfunction

  // State registers
  logic            run;          // 0 only in the first cycle after reset release
  logic [DW-1:0]   div;
  logic [RW-1:0]   row;
  logic [KEYS-1:0] frame_buf;
  logic [KEYS-1:0] prev_frame;
  logic [SW-1:0]   stable_cnt;
  logic [KEYS-1:0] pending;

  // Next-state values
  logic            run_nxt;
  logic [DW-1:0]   div_nxt;
  logic [RW-1:0]   row_nxt;
  logic [ROWS-1:0] row_n_nxt;
  logic [KEYS-1:0] frame_buf_nxt;
  logic [KEYS-1:0] prev_nxt;
  logic [SW-1:0]   stable_nxt;
  logic [KEYS-1:0] state_nxt;
  logic [KEYS-1:0] pending_nxt;
  logic            valid_nxt;
  logic [CW-1:0]   code_nxt;
  logic            drop_nxt;

  // Combinational helpers
  int              row_base;
  logic [COLS-1:0] raw_row;
  logic [KEYS-1:0] frame_now;
  logic            sample;
  logic            frame_end;
  logic            key_upd;
  logic [KEYS-1:0] rise;
  logic [KEYS-1:0] pend_all;
  logic            take;

  // Row scan, column sampling and frame debounce.
  always_comb begin
    row_base  = int'(row) * COLS;
    raw_row   = ~col_n ^ INVERT_MASK[row_base +: COLS];
    sample    = run && (div == DIV_LAST);
    frame_end = sample && (row == ROW_LAST);
    // The frame under evaluation includes the row being sampled this cycle.
    frame_now = frame_buf;
    frame_now[row_base +: COLS] = raw_row;

    if (!run) begin
      // The extra start cycle gives row 0 its full SCAN_DIV cycles on the first pass.
      run_nxt = 1'b1;
      div_nxt = '0;
      row_nxt = '0;
    end else if (sample) begin
      run_nxt = 1'b1;
      div_nxt = '0;
      row_nxt = (row == ROW_LAST) ? '0 : row + RW'(1);
    end else begin
      run_nxt = 1'b1;
      div_nxt = div + DW'(1);
      row_nxt = row;
    end
    row_n_nxt     = ~(ROW_ONE << row_nxt);
    frame_buf_nxt = sample ? frame_now : frame_buf;

    if (frame_end) begin
      if (frame_now == prev_frame) begin
        prev_nxt   = prev_frame;
        stable_nxt = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + SW'(1);
      end else begin
        prev_nxt   = frame_now;
        stable_nxt = SW'(1);
      end
    end else begin
      prev_nxt   = prev_frame;
      stable_nxt = stable_cnt;
    end
  end

  // Level update, event queueing and output handshake stage.
  always_comb begin
    key_upd   = (stable_cnt == STABLE_MAX);
    state_nxt = key_upd ? prev_frame : key_state;
    rise      = key_upd ? (prev_frame & ~key_state) : '0;
    drop_nxt  = |(rise & pending);
    // Bits rising this cycle are eligible for presentation right away.
    pend_all  = pending | rise;
    take      = !key_valid || key_ready;

    if (take) begin
      if (|pend_all) begin
        valid_nxt   = 1'b1;
        code_nxt    = lowest_idx(pend_all);
        pending_nxt = pend_all & ~(KEY_ONE << code_nxt);
      end else begin
        valid_nxt   = 1'b0;
        code_nxt    = key_code;
        pending_nxt = pend_all;
      end
    end else begin
      valid_nxt   = key_valid;
      code_nxt    = key_code;
      pending_nxt = pend_all;
    end
  end

  // Register all state and outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      div        <= '0;
      row        <= '0;
      row_n      <= '1;
      frame_buf  <= '0;
      prev_frame <= '0;
      stable_cnt <= '0;
      key_state  <= '0;
      pending    <= '0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_drop   <= 1'b0;
    end else begin
      run        <= run_nxt;
      div        <= div_nxt;
      row        <= row_nxt;
      row_n      <= row_n_nxt;
      frame_buf  <= frame_buf_nxt;
      prev_frame <= prev_nxt;
      stable_cnt <= stable_nxt;
      key_state  <= state_nxt;
      pending    <= pending_nxt;
      key_valid  <= valid_nxt;
      key_code   <= code_nxt;
      key_drop   <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Directed bench for keypad_scan_decoder (4x4, SCAN_DIV 4, 3 debounce frames).
// A behavioural key matrix drives col_n from row_n. A second instance uses
// INVERT_MASK = 16'h0001.
module tb_keypad_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [3:0]  row_n, row_n2;
  logic [3:0]  col_n, col_n2;
  logic [15:0] key_state, key_state2;
  logic        key_valid, key_valid2;
  logic [3:0]  key_code, key_code2;
  logic        key_ready, key_ready2;
  logic        key_drop, key_drop2;
  logic [15:0] keys, keys2;

  int errors = 0;
  int checks = 0;
  int ev_codes[$];
  int drop_cnt = 0;
  int n0;
  int cnt5;

  always #5 clk = ~clk;

  keypad_scan_decoder #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(3),
                        .INVERT_MASK(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .key_state(key_state), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .key_drop(key_drop));

  keypad_scan_decoder #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(3),
                        .INVERT_MASK(16'h0001)) dut2 (
    .clk(clk), .rst_n(rst2_n), .row_n(row_n2), .col_n(col_n2),
    .key_state(key_state2), .key_valid(key_valid2), .key_code(key_code2),
    .key_ready(key_ready2), .key_drop(key_drop2));

  // Key matrix model: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  always_comb begin
    col_n2 = 4'hF;
    for (int r2 = 0; r2 < 4; r2++)
      for (int c2 = 0; c2 < 4; c2++)
        if (!row_n2[r2] && keys2[r2*4+c2]) col_n2[c2] = 1'b0;
  end

  // Record delivered events and drop pulses of the main instance.
  always @(posedge clk) begin
    if (rst_n && key_valid && key_ready) ev_codes.push_back(int'(key_code));
    if (rst_n && key_drop) drop_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [15:0] exp, input string tag);
    int n;
    n = 0;
    while (key_state !== exp && n < 120) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(key_state), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    keys = 16'h0000; keys2 = 16'h0000;
    key_ready = 1'b1; key_ready2 = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_row_n", 32'(row_n), 32'h0000000F);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_state", 32'(key_state), 32'h0);
    check("rst_code",  32'(key_code), 32'h0);
    check("rst_drop",  32'(key_drop), 32'h0);

    // Row sequence after release: E x4, D x4, B x4, 7 x4, then E again
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      logic [3:0] exp_row;
      @(negedge clk);
      exp_row = ~(4'b0001 << (((k - 1) / 4) % 4));
      check("row_scan", 32'(row_n), 32'(exp_row));
    end

    // Key 6 steady press: debounced exactly 49 cycles after pressing
    keys = 16'h0040;
    repeat (48) @(negedge clk);
    check("k6_before", 32'(key_state), 32'h0);
    @(negedge clk);
    check("k6_state", 32'(key_state), 32'h0040);
    check("k6_valid", 32'(key_valid), 32'h1);
    check("k6_code",  32'(key_code), 32'h6);
    @(negedge clk);
    check("k6_valid_done", 32'(key_valid), 32'h0);
    check("k6_ev_count", 32'(ev_codes.size()), 32'h1);
    check("k6_ev_code",  32'(ev_codes[0]), 32'h6);
    n0 = ev_codes.size();
    keys = 16'h0000;
    wait_state(16'h0000, "k6_release");
    repeat (4) @(negedge clk);
    check("k6_release_noev", 32'(ev_codes.size()), 32'(n0));
    check("k6_release_valid", 32'(key_valid), 32'h0);

    // Key 0 bounces once per frame for four frames, then steady
    keys = 16'h0001; repeat (16) @(negedge clk);
    keys = 16'h0000; repeat (16) @(negedge clk);
    keys = 16'h0001; repeat (16) @(negedge clk);
    keys = 16'h0000; repeat (16) @(negedge clk);
    check("bounce_state", 32'(key_state), 32'h0);
    n0 = ev_codes.size();
    keys = 16'h0001;
    wait_state(16'h0001, "bounce_settled");
    repeat (2) @(negedge clk);
    check("bounce_ev_count", 32'(ev_codes.size()), 32'(n0 + 1));
    check("bounce_ev_code",  32'(ev_codes[ev_codes.size()-1]), 32'h0);
    keys = 16'h0000;
    wait_state(16'h0000, "bounce_release");

    // Keys 3 and 9 debounced together with the consumer stalled
    key_ready = 1'b0;
    keys = 16'h0208;
    wait_state(16'h0208, "k39_state");
    check("k39_valid", 32'(key_valid), 32'h1);
    check("k39_code3", 32'(key_code), 32'h3);
    repeat (3) @(negedge clk);
    check("k39_hold_valid", 32'(key_valid), 32'h1);
    check("k39_hold_code",  32'(key_code), 32'h3);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("k39_valid9", 32'(key_valid), 32'h1);
    check("k39_code9",  32'(key_code), 32'h9);
    repeat (2) @(negedge clk);
    check("k39_hold9", 32'(key_code), 32'h9);
    key_ready = 1'b1;
    @(negedge clk);
    check("k39_empty", 32'(key_valid), 32'h0);
    keys = 16'h0000;
    wait_state(16'h0000, "k39_release");

    // Key 5 re-pressed while its event is still pending behind key 3
    check("drop_none_yet", 32'(drop_cnt), 32'h0);
    key_ready = 1'b0;
    keys = 16'h0028;
    wait_state(16'h0028, "k5_state");
    check("k5_code3", 32'(key_code), 32'h3);
    keys = 16'h0008;
    wait_state(16'h0008, "k5_released");
    keys = 16'h0028;
    wait_state(16'h0028, "k5_repressed");
    check("k5_drop_hi", 32'(key_drop), 32'h1);
    @(negedge clk);
    check("k5_drop_lo", 32'(key_drop), 32'h0);
    check("k5_drop_cnt", 32'(drop_cnt), 32'h1);
    key_ready = 1'b1;
    @(negedge clk);
    check("k5_valid", 32'(key_valid), 32'h1);
    check("k5_code",  32'(key_code), 32'h5);
    @(negedge clk);
    check("k5_empty", 32'(key_valid), 32'h0);
    cnt5 = 0;
    foreach (ev_codes[i]) if (ev_codes[i] == 5) cnt5++;
    check("k5_once", 32'(cnt5), 32'h1);
    keys = 16'h0000;
    wait_state(16'h0000, "k5_release");

    // Asynchronous reset mid-frame while an event is presented
    key_ready = 1'b0;
    keys = 16'h0040;
    wait_state(16'h0040, "mid_state");
    check("mid_valid", 32'(key_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_row_n", 32'(row_n), 32'h0000000F);
    check("mid_rst_valid", 32'(key_valid), 32'h0);
    check("mid_rst_state", 32'(key_state), 32'h0);
    check("mid_rst_code",  32'(key_code), 32'h0);
    keys = 16'h0000;
    key_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n0 = ev_codes.size();
    repeat (80) @(negedge clk);
    check("mid_no_stale", 32'(ev_codes.size()), 32'(n0));
    check("mid_state0",   32'(key_state), 32'h0);

    // Inverted key 0: idle reads as pressed, pressing reads as released
    rst2_n = 1'b1;
    repeat (49) @(negedge clk);
    check("inv_before", 32'(key_state2), 32'h0);
    @(negedge clk);
    check("inv_state", 32'(key_state2), 32'h0001);
    check("inv_valid", 32'(key_valid2), 32'h1);
    check("inv_code",  32'(key_code2), 32'h0);
    @(negedge clk);
    check("inv_done", 32'(key_valid2), 32'h0);
    keys2 = 16'h0001;
    for (int w = 0; w < 120 && key_state2 !== 16'h0000; w++) @(negedge clk);
    check("inv_pressed", 32'(key_state2), 32'h0);
    check("inv_no_event", 32'(key_valid2), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
